// File: rtl/logic_result_checker.sv
// Result checker for a word-wide logic gate under test: recomputes the expected
// bitwise result one cycle after acceptance and keeps pass/fail counts plus a first-failure capture.
module logic_result_checker #(
  parameter int unsigned w = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop_on_fail,
  input  logic [15:0]   num_vectors,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [w-1:0]  in_0,
  input  logic [w-1:0]  in_1,
  input  logic [w-1:0]  result,
  output logic [15:0]   pass_cnt,
  output logic [15:0]   fail_cnt,
  output logic          ff_valid,
  output logic [2:0]    ff_op,
  output logic [w-1:0]  ff_exp,
  output logic [w-1:0]  ff_got,
  output logic [15:0]   ff_idx,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  acc_idx;
  logic [CW-1:0]  nv_q;
  logic           sof_q;

  logic           s1_valid;
  logic [2:0]     s1_op;
  logic [w-1:0]   s1_in0;
  logic [w-1:0]   s1_in1;
  logic [w-1:0]   s1_res;
  logic [CW-1:0]  s1_idx;

  logic [w-1:0]   exp_c;
  logic           illegal_c;
  logic           mismatch_c;
  logic           accept_c;
  logic [CW-1:0]  acc_next_c;

  // Reference model of the gate; illegal ops expect all zeros and always fail.
  always_comb begin
    exp_c     = '0;
    illegal_c = 1'b0;
    case (s1_op)
      3'b000:  exp_c = s1_in0 & s1_in1;
      3'b001:  exp_c = s1_in0 | s1_in1;
      3'b010:  exp_c = s1_in0 ^ s1_in1;
      3'b011:  exp_c = ~(s1_in0 & s1_in1);
      3'b100:  exp_c = ~(s1_in0 | s1_in1);
      3'b101:  exp_c = ~(s1_in0 ^ s1_in1);
      default: illegal_c = 1'b1;
    endcase
  end

  assign mismatch_c = s1_valid && (illegal_c || (exp_c != s1_res));
  assign accept_c   = in_valid && in_ready;
  assign acc_next_c = acc_idx + CW'(accept_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_idx  <= '0;
      nv_q     <= '0;
      sof_q    <= 1'b0;
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_in0   <= '0;
      s1_in1   <= '0;
      s1_res   <= '0;
      s1_idx   <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      ff_valid <= 1'b0;
      ff_op    <= '0;
      ff_exp   <= '0;
      ff_got   <= '0;
      ff_idx   <= '0;
    end else begin
      // Stage 1: capture the accepted vector and its index
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_op   <= op;
        s1_in0  <= in_0;
        s1_in1  <= in_1;
        s1_res  <= result;
        s1_idx  <= acc_idx;
        acc_idx <= acc_next_c;
      end

      // Stage 2: saturating counters and first-failure capture
      if (s1_valid) begin
        if (mismatch_c) begin
          if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 16'd1;
          if (!ff_valid) begin
            ff_valid <= 1'b1;
            ff_op    <= s1_op;
            ff_exp   <= exp_c;
            ff_got   <= s1_res;
            ff_idx   <= s1_idx;
          end
        end else if (pass_cnt != CNT_MAX) begin
          pass_cnt <= pass_cnt + 16'd1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            in_ready <= (num_vectors != 16'd0);
            nv_q     <= num_vectors;
            sof_q    <= stop_on_fail;
            acc_idx  <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            ff_valid <= 1'b0;
          end
        end
        RUN: begin
          // A vector accepted on the same edge as a stopping fail is still in stage 1
          if ((acc_next_c == nv_q) || (sof_q && mismatch_c)) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_result_checker.sv
// Directed bench for logic_result_checker at widths 8, 16 and 64 sharing one clock,
// reset and vector bus; each instance has its own start and outputs.
module tb_logic_result_checker;

  logic        clk = 1'b0;
  logic        rst, sof, in_valid;
  logic        start8, start16, start64;
  logic [15:0] nv;
  logic [2:0]  op;
  logic [63:0] in0, in1, res;

  logic        rdy8, ffv8, busy8, done8;
  logic [15:0] pass8, fail8, ffidx8;
  logic [2:0]  ffop8;
  logic [7:0]  ffexp8, ffgot8;

  logic        rdy16, ffv16, busy16, done16;
  logic [15:0] pass16, fail16, ffidx16;
  logic [2:0]  ffop16;
  logic [15:0] ffexp16, ffgot16;

  logic        rdy64, ffv64, busy64, done64;
  logic [15:0] pass64, fail64, ffidx64;
  logic [2:0]  ffop64;
  logic [63:0] ffexp64, ffgot64;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  logic_result_checker #(.w(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .stop_on_fail(sof), .num_vectors(nv),
    .in_valid(in_valid), .in_ready(rdy8), .op(op), .in_0(in0[7:0]), .in_1(in1[7:0]),
    .result(res[7:0]), .pass_cnt(pass8), .fail_cnt(fail8), .ff_valid(ffv8), .ff_op(ffop8),
    .ff_exp(ffexp8), .ff_got(ffgot8), .ff_idx(ffidx8), .busy(busy8), .done(done8));

  logic_result_checker #(.w(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .stop_on_fail(sof), .num_vectors(nv),
    .in_valid(in_valid), .in_ready(rdy16), .op(op), .in_0(in0[15:0]), .in_1(in1[15:0]),
    .result(res[15:0]), .pass_cnt(pass16), .fail_cnt(fail16), .ff_valid(ffv16), .ff_op(ffop16),
    .ff_exp(ffexp16), .ff_got(ffgot16), .ff_idx(ffidx16), .busy(busy16), .done(done16));

  logic_result_checker #(.w(64)) u64 (
    .clk(clk), .rst(rst), .start(start64), .stop_on_fail(sof), .num_vectors(nv),
    .in_valid(in_valid), .in_ready(rdy64), .op(op), .in_0(in0), .in_1(in1),
    .result(res), .pass_cnt(pass64), .fail_cnt(fail64), .ff_valid(ffv64), .ff_op(ffop64),
    .ff_exp(ffexp64), .ff_got(ffgot64), .ff_idx(ffidx64), .busy(busy64), .done(done64));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      8:       return rdy8;
      16:      return rdy16;
      default: return rdy64;
    endcase
  endfunction

  function automatic logic dn(input int sel);
    case (sel)
      8:       return done8;
      16:      return done16;
      default: return done64;
    endcase
  endfunction

  task automatic start_run(input int sel, input logic [15:0] n, input logic s);
    nv  = n;
    sof = s;
    case (sel)
      8:       start8  = 1'b1;
      16:      start16 = 1'b1;
      default: start64 = 1'b1;
    endcase
    tick();
    start8  = 1'b0;
    start16 = 1'b0;
    start64 = 1'b0;
  endtask

  task automatic send(input int sel, input logic [2:0] o, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] r);
    op = o; in0 = a; in1 = b; res = r;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rdy(sel)) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int sel, output int cyc);
    cyc = 0;
    while (!dn(sel) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("done_reached", 64'(dn(sel)), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, acc;
    logic indep, r;

    rst = 1'b1; start8 = 1'b0; start16 = 1'b0; start64 = 1'b0;
    sof = 1'b0; nv = '0; in_valid = 1'b0; op = '0; in0 = '0; in1 = '0; res = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 64'(rdy8), 64'd0);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_pass", 64'(pass8), 64'd0);
    check("rst_fail", 64'(fail8), 64'd0);
    check("rst_ffv", 64'(ffv8), 64'd0);
    check("rst_busy64", 64'(busy64), 64'd0);

    // Three passing vectors, w=8
    start_run(8, 16'd3, 1'b0);
    check("run_busy", 64'(busy8), 64'd1);
    check("run_ready", 64'(rdy8), 64'd1);
    send(8, 3'b011, 64'hF0, 64'h3C, 64'hCF);
    send(8, 3'b000, 64'hF0, 64'h3C, 64'h30);
    send(8, 3'b010, 64'hFF, 64'h0F, 64'hF0);
    wait_done(8, cyc);
    check("v3_pass", 64'(pass8), 64'd3);
    check("v3_fail", 64'(fail8), 64'd0);
    check("v3_ffv", 64'(ffv8), 64'd0);
    check("v3_busy", 64'(busy8), 64'd0);

    // Stop on first fail: vector index 1 is a bad NOR; index 2 lands on the fail edge
    start_run(8, 16'd5, 1'b1);
    send(8, 3'b001, 64'h0F, 64'hF0, 64'hFF);
    send(8, 3'b100, 64'h00, 64'h00, 64'h00);
    send(8, 3'b000, 64'hFF, 64'h0F, 64'h0F);
    check("sof_ready_drop", 64'(rdy8), 64'd0);
    check("sof_ffv_early", 64'(ffv8), 64'd1);
    wait_done(8, cyc);
    check("sof_fail", 64'(fail8), 64'd1);
    check("sof_pass", 64'(pass8), 64'd2);
    check("sof_ff_op", 64'(ffop8), 64'd4);
    check("sof_ff_exp", 64'(ffexp8), 64'hFF);
    check("sof_ff_got", 64'(ffgot8), 64'h00);
    check("sof_ff_idx", 64'(ffidx8), 64'd1);

    // Zero-length run, restarted from DONE
    start_run(8, 16'd0, 1'b0);
    check("nv0_ready", 64'(rdy8), 64'd0);
    check("nv0_ffv_clr", 64'(ffv8), 64'd0);
    wait_done(8, cyc);
    check("nv0_latency_ok", 64'(cyc <= 2), 64'd1);
    check("nv0_pass", 64'(pass8), 64'd0);
    check("nv0_fail", 64'(fail8), 64'd0);

    // Reset mid-run after two accepts
    start_run(8, 16'd5, 1'b0);
    send(8, 3'b000, 64'hF0, 64'h3C, 64'h31);
    send(8, 3'b000, 64'hF0, 64'h3C, 64'h30);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_ready", 64'(rdy8), 64'd0);
    check("mrst_busy", 64'(busy8), 64'd0);
    check("mrst_done", 64'(done8), 64'd0);
    check("mrst_pass", 64'(pass8), 64'd0);
    check("mrst_fail", 64'(fail8), 64'd0);
    check("mrst_ffv", 64'(ffv8), 64'd0);
    check("mrst_ff_op", 64'(ffop8), 64'd0);
    check("mrst_ff_exp", 64'(ffexp8), 64'd0);
    check("mrst_ff_got", 64'(ffgot8), 64'd0);
    check("mrst_ff_idx", 64'(ffidx8), 64'd0);

    // Reset wins over a simultaneous start
    start8 = 1'b1; rst = 1'b1; nv = 16'd2;
    tick();
    start8 = 1'b0; rst = 1'b0;
    check("rst_prio_busy", 64'(busy8), 64'd0);
    check("rst_prio_ready", 64'(rdy8), 64'd0);

    start_run(8, 16'd1, 1'b0);
    send(8, 3'b101, 64'hF0, 64'h3C, 64'h33);
    wait_done(8, cyc);
    check("post_rst_pass", 64'(pass8), 64'd1);
    check("post_rst_fail", 64'(fail8), 64'd0);

    // Illegal op, w=16
    start_run(16, 16'd1, 1'b0);
    send(16, 3'b111, 64'h1234, 64'h5678, 64'h0000);
    wait_done(16, cyc);
    check("ill_fail", 64'(fail16), 64'd1);
    check("ill_pass", 64'(pass16), 64'd0);
    check("ill_ffv", 64'(ffv16), 64'd1);
    check("ill_ff_exp", 64'(ffexp16), 64'h0000);
    check("ill_ff_op", 64'(ffop16), 64'd7);

    // 100 random NAND vectors with random in_valid, w=64
    start_run(64, 16'd100, 1'b0);
    acc = 0;
    indep = 1'b1;
    op  = 3'b011;
    in0 = {$urandom, $urandom};
    in1 = {$urandom, $urandom};
    res = ~(in0 & in1);
    for (int c = 0; c < 2000 && acc < 100; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      r = rdy64;
      in_valid = ~in_valid;
      #1;
      if (rdy64 !== r) indep = 1'b0;
      in_valid = ~in_valid;
      #1;
      @(posedge clk);
      #1;
      if (in_valid && r) begin
        acc++;
        in0 = {$urandom, $urandom};
        in1 = {$urandom, $urandom};
        res = ~(in0 & in1);
      end
    end
    in_valid = 1'b0;
    wait_done(64, cyc);
    check("rnd_accepted", 64'(acc), 64'd100);
    check("rnd_pass", 64'(pass64), 64'd100);
    check("rnd_fail", 64'(fail64), 64'd0);
    check("rnd_ffv", 64'(ffv64), 64'd0);
    check("rnd_ready_indep", 64'(indep), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
